// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Double-dabble digit correction: a digit of 5..9 becomes >=8 so the next shift carries.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? 4'(d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Combinational add-3 correction cell for one BCD digit.
module bin2bcd_seq_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] digit_c
);

  assign digit_c = add3(digit);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one shift per clock.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam int unsigned SR_W  = BCD_W + BIN_W;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [SR_W-1:0]    sr_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [BIN_W-1:0]   bin_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bin2bcd_seq_add3 u_add3 (
      .digit   (bcd_sr[4*g +: 4]),
      .digit_c (bcd_adj[4*g +: 4])
    );
  end

  // Corrected digits and the binary remainder shift as one word; bcd MSB falls off.
  assign sr_nxt  = {bcd_adj, bin_sr} << 1;
  assign bcd_nxt = sr_nxt[SR_W-1:BIN_W];
  assign bin_nxt = sr_nxt[BIN_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd_sr <= '0;
            cnt    <= CNT_W'(BIN_W);
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_sr <= bcd_nxt;
          bin_sr <= bin_nxt;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_out <= bcd_nxt;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default 8/3 instance plus a 6/2 sweep instance.
module tb_bin2bcd_seq;

  typedef struct {
    logic [11:0] exp;
    int          acc;
  } item_a_t;

  typedef struct {
    logic [7:0] exp;
    int         acc;
  } item_b_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic [7:0]  bin_a = '0;
  logic        busy_a, done_a;
  logic [11:0] bcd_a;
  logic        start_b = 1'b0;
  logic [5:0]  bin_b = '0;
  logic        busy_b, done_b;
  logic [7:0]  bcd_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  item_a_t q_a[$];
  item_b_t q_b[$];

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin_in(bin_a),
    .busy(busy_a), .done(done_a), .bcd_out(bcd_a)
  );

  bin2bcd_seq #(.BIN_W(6), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin_in(bin_b),
    .busy(busy_b), .done(done_b), .bcd_out(bcd_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitors: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        item_a_t it;
        it = q_a.pop_front();
        chk("a_bcd_out", 32'(bcd_a), 32'(it.exp));
        chk("a_latency", 32'(cyc - it.acc), 32'd8);
      end
    end
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        item_b_t it;
        it = q_b.pop_front();
        chk("b_bcd_out", 32'(bcd_b), 32'(it.exp));
        chk("b_latency", 32'(cyc - it.acc), 32'd6);
      end
    end
  end

  // Wait (bounded) for done on instance A; returns number of busy cycles seen.
  task automatic wait_done_a(output int nbusy);
    bit seen = 0;
    nbusy = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (busy_a) nbusy++;
      if (done_a) seen = 1;
    end
    if (!seen) chk("a_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic conv_a(input logic [7:0] v, input logic [11:0] exp);
    int nb;
    @(posedge clk); #1;
    start_a = 1'b1;
    bin_a   = v;
    q_a.push_back('{exp: exp, acc: cyc + 1});
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_done_a(nb);
    chk("a_busy_cycles", 32'(nb), 32'd8);
  endtask

  task automatic conv_b(input logic [5:0] v, input logic [7:0] exp);
    bit seen = 0;
    int nb = 0;
    @(posedge clk); #1;
    start_b = 1'b1;
    bin_b   = v;
    q_b.push_back('{exp: exp, acc: cyc + 1});
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (busy_b) nb++;
      if (done_b) seen = 1;
    end
    if (!seen) chk("b_done_timeout", 32'd0, 32'd1);
    chk("b_busy_cycles", 32'(nb), 32'd6);
  endtask

  initial begin
    int nb;
    int ndone;
    logic [7:0] exp_b;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    chk("reset_bcd", 32'(bcd_a), 32'd0);

    // Directed conversions including zero and decade boundaries.
    conv_a(8'd255, 12'h255);
    conv_a(8'd0,   12'h000);
    conv_a(8'd99,  12'h099);
    conv_a(8'd100, 12'h100);
    conv_a(8'd9,   12'h009);
    conv_a(8'd10,  12'h010);

    // Start pulses during a conversion are ignored.
    @(posedge clk); #1;
    start_a = 1'b1;
    bin_a   = 8'd42;
    q_a.push_back('{exp: 12'h042, acc: cyc + 1});
    @(posedge clk); #1;
    start_a = 1'b0;
    bin_a   = 8'd7;
    repeat (2) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done_a(nb);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("ignored_start_extra_done", 32'(ndone), 32'd0);
    chk("hold_bcd_after_done", 32'(bcd_a), 32'h042);

    // Start held high: back-to-back acceptance every 9 cycles.
    @(posedge clk); #1;
    start_a = 1'b1;
    bin_a   = 8'd59;
    q_a.push_back('{exp: 12'h059, acc: cyc + 1});
    wait_done_a(nb);
    bin_a = 8'd60;
    q_a.push_back('{exp: 12'h060, acc: cyc + 1});
    wait_done_a(nb);
    start_a = 1'b0;
    chk("b2b_busy_second", 32'(nb), 32'd8);

    // Asynchronous reset mid-conversion aborts without a done pulse.
    @(posedge clk); #1;
    start_a = 1'b1;
    bin_a   = 8'd200;
    q_a.push_back('{exp: 12'h200, acc: cyc + 1});
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    void'(q_a.pop_front());
    #1;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_bcd", 32'(bcd_a), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_a) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    conv_a(8'd200, 12'h200);

    // Narrow instance: full sweep of the 6-bit input range.
    for (int v = 0; v < 64; v++) begin
      exp_b = 8'(((v / 10) << 4) | (v % 10));
      conv_b(6'(v), exp_b);
    end

    repeat (4) @(negedge clk);
    chk("a_queue_empty", 32'(q_a.size()), 32'd0);
    chk("b_queue_empty", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
